// File: rtl/stopwatch_lap_ctrl_if.sv
// Stopwatch button/display bundle.
// master: board side, drives the two push-buttons and observes the display.
// slave : stopwatch core, samples the buttons and drives time, segments, status.
//   start_stop, lap            button levels (asynchronous to clk)
//   time_bcd                   {mm10,mm1,ss10,ss1,cs10,cs1} 4-bit BCD digits
//   mm10..cs1                  active-low segments {g,f,e,d,c,b,a}
//   running, lap_active        RUN state / display frozen by lap
//   overflow                   one-cycle pulse on wrap to 00:00.00
interface stopwatch_lap_ctrl_if;
  logic        start_stop;
  logic        lap;
  logic [23:0] time_bcd;
  logic [6:0]  mm10;
  logic [6:0]  mm1;
  logic [6:0]  ss10;
  logic [6:0]  ss1;
  logic [6:0]  cs10;
  logic [6:0]  cs1;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport master (
    output start_stop, lap,
    input  time_bcd, mm10, mm1, ss10, ss1, cs10, cs1,
    input  running, lap_active, overflow
  );

  modport slave (
    input  start_stop, lap,
    output time_bcd, mm10, mm1, ss10, ss1, cs10, cs1,
    output running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch core: start/stop/resume FSM, lap display freeze and a cascaded
// BCD time base (cs 00..99, ss 00..59, mm 00..MAX_MIN) on a single clock.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   sw    slave side of stopwatch_lap_ctrl_if (buttons in, display/status out)
// Parameters:
//   TICK_DIV     clock cycles per centisecond tick (>= 2)
//   MAX_MIN      highest minute value before wrap (1..99)
//   SYNC_STAGES  synchronizer flops per button (>= 2)
module stopwatch_lap_ctrl #(
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned MAX_MIN     = 59,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_lap_ctrl_if.slave  sw
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [3:0] MAX_MM10 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MM1  = 4'(MAX_MIN % 10);

  typedef struct packed {
    logic [3:0] mm10;
    logic [3:0] mm1;
    logic [3:0] ss10;
    logic [3:0] ss1;
    logic [3:0] cs10;
    logic [3:0] cs1;
  } bcd_time_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Button synchronizers and registered rising-edge detectors
  logic [SYNC_STAGES-1:0] start_sync_q;
  logic [SYNC_STAGES-1:0] lap_sync_q;
  logic                   start_prev_q;
  logic                   lap_prev_q;
  logic                   start_edge_q;
  logic                   lap_edge_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync_q <= '0;
      lap_sync_q   <= '0;
      start_prev_q <= 1'b0;
      lap_prev_q   <= 1'b0;
      start_edge_q <= 1'b0;
      lap_edge_q   <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], sw.start_stop};
      lap_sync_q   <= {lap_sync_q[SYNC_STAGES-2:0], sw.lap};
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      lap_prev_q   <= lap_sync_q[SYNC_STAGES-1];
      start_edge_q <= start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
      lap_edge_q   <= lap_sync_q[SYNC_STAGES-1] & ~lap_prev_q;
    end
  end

  // Control state and datapath registers
  state_t              state_q;
  state_t              state_d;
  logic [PRESC_W-1:0]  presc_q;
  bcd_time_t           live_q;
  bcd_time_t           lap_q;
  logic                lap_active_q;
  logic                running_q;
  logic                overflow_q;

  logic                tick_c;
  logic                clear_c;
  logic                lap_toggle_c;
  bcd_time_t           live_inc_c;
  logic                at_max_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and control strobes; start beats lap in the same cycle
  always_comb begin
    state_d      = state_q;
    tick_c       = 1'b0;
    clear_c      = 1'b0;
    lap_toggle_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        tick_c = (presc_q == PRESC_LAST);
        if (start_edge_q) begin
          state_d = ST_PAUSE;
        end else if (lap_edge_q) begin
          lap_toggle_c = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (start_edge_q) begin
          state_d = ST_RUN;
        end else if (lap_edge_q) begin
          clear_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Prescaler advances only in RUN, so a partial tick survives a pause
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (clear_c) begin
      presc_q <= '0;
    end else if (state_q == ST_RUN) begin
      presc_q <= tick_c ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // Next BCD value: each digit rolls only when all lower digits roll
  always_comb begin
    live_inc_c = live_q;
    at_max_c   = (live_q.mm10 == MAX_MM10) && (live_q.mm1 == MAX_MM1) &&
                 (live_q.ss10 == 4'd5) && (live_q.ss1 == 4'd9) &&
                 (live_q.cs10 == 4'd9) && (live_q.cs1 == 4'd9);

    if (live_q.cs1 != 4'd9) begin
      live_inc_c.cs1 = live_q.cs1 + 4'd1;
    end else begin
      live_inc_c.cs1 = 4'd0;
      if (live_q.cs10 != 4'd9) begin
        live_inc_c.cs10 = live_q.cs10 + 4'd1;
      end else begin
        live_inc_c.cs10 = 4'd0;
        if (live_q.ss1 != 4'd9) begin
          live_inc_c.ss1 = live_q.ss1 + 4'd1;
        end else begin
          live_inc_c.ss1 = 4'd0;
          if (live_q.ss10 != 4'd5) begin
            live_inc_c.ss10 = live_q.ss10 + 4'd1;
          end else begin
            live_inc_c.ss10 = 4'd0;
            if ((live_q.mm10 == MAX_MM10) && (live_q.mm1 == MAX_MM1)) begin
              live_inc_c.mm10 = 4'd0;
              live_inc_c.mm1  = 4'd0;
            end else if (live_q.mm1 != 4'd9) begin
              live_inc_c.mm1 = live_q.mm1 + 4'd1;
            end else begin
              live_inc_c.mm1  = 4'd0;
              live_inc_c.mm10 = live_q.mm10 + 4'd1;
            end
          end
        end
      end
    end
  end

  // Live count and wrap pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= tick_c & at_max_c;
      if (clear_c) begin
        live_q <= '0;
      end else if (tick_c) begin
        live_q <= live_inc_c;
      end
    end
  end

  // Lap freeze; the latch takes the pre-increment value on a tick cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else if (clear_c) begin
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else if (lap_toggle_c) begin
      lap_active_q <= ~lap_active_q;
      if (!lap_active_q) begin
        lap_q <= live_q;
      end
    end
  end

  // Registered RUN indication, aligned with the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_q <= 1'b0;
    end else begin
      running_q <= (state_d == ST_RUN);
    end
  end

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes blank the digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  bcd_time_t disp_c;
  assign disp_c = lap_active_q ? lap_q : live_q;

  assign sw.time_bcd   = disp_c;
  assign sw.mm10       = seg7(disp_c.mm10);
  assign sw.mm1        = seg7(disp_c.mm1);
  assign sw.ss10       = seg7(disp_c.ss10);
  assign sw.ss1        = seg7(disp_c.ss1);
  assign sw.cs10       = seg7(disp_c.cs10);
  assign sw.cs1        = seg7(disp_c.cs1);
  assign sw.running    = running_q;
  assign sw.lap_active = lap_active_q;
  assign sw.overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl: directed scenarios with literal expectations
// plus randomized button/reset traffic, all checked every cycle against a
// behavioural model that keeps time as a plain centisecond integer.
module tb_stopwatch_lap_ctrl;

  localparam int unsigned TD    = 2;
  localparam int unsigned MM    = 1;
  localparam int unsigned SS    = 2;
  localparam int          TOTAL = (MM + 1) * 6000;

  localparam bit [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_lap_ctrl_if sw_if ();

  stopwatch_lap_ctrl #(
    .TICK_DIV    (TD),
    .MAX_MIN     (MM),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  int checks = 0;
  int errors = 0;

  // st: 0 idle, 1 run, 2 pause; cnt: centiseconds since 00:00.00
  typedef struct {
    int        st;
    int        presc;
    int        cnt;
    int        lapv;
    bit        lapa;
    bit        ovf;
    bit [15:0] hs;
    bit [15:0] hl;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.presc = 0; r.cnt = 0; r.lapv = 0;
    r.lapa = 1'b0; r.ovf = 1'b0; r.hs = '0; r.hl = '0;
    return r;
  endfunction

  // One clock of the stopwatch rules; a button press acts SS+1 edges after sampling
  function automatic model_t step(model_t c, logic s_in, logic l_in);
    model_t n;
    bit es, el, tick;
    n = c;
    n.hs = {c.hs[14:0], s_in};
    n.hl = {c.hl[14:0], l_in};
    es = n.hs[SS+1] && !n.hs[SS+2];
    el = n.hl[SS+1] && !n.hl[SS+2];
    tick = (c.st == 1) && (c.presc == TD - 1);
    n.ovf = tick && (c.cnt == TOTAL - 1);
    if (tick) n.cnt = (c.cnt + 1) % TOTAL;
    if (c.st == 1) n.presc = tick ? 0 : c.presc + 1;
    if (es) begin
      n.st = (c.st == 1) ? 2 : 1;
    end else if (el) begin
      if (c.st == 1) begin
        if (!c.lapa) begin
          n.lapv = c.cnt;
          n.lapa = 1'b1;
        end else begin
          n.lapa = 1'b0;
        end
      end else if (c.st == 2) begin
        n.cnt = 0; n.presc = 0; n.lapa = 1'b0; n.lapv = 0; n.st = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= step(m, sw_if.start_stop, sw_if.lap);
  end

  function automatic logic [23:0] to_bcd(int c);
    int mn, sec, cs;
    mn  = c / 6000;
    sec = (c / 100) % 60;
    cs  = c % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10), 4'(sec % 10),
            4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic logic [68:0] expect_out(model_t c);
    logic [23:0] t;
    logic [41:0] s;
    t = to_bcd(c.lapa ? c.lapv : c.cnt);
    for (int i = 0; i < 6; i++) s[i*7 +: 7] = SEG[int'(t[i*4 +: 4])];
    return {t, s, c.st == 1, c.lapa, c.ovf};
  endfunction

  task automatic cycle_check();
    logic [68:0] act, exp;
    act = {sw_if.time_bcd, sw_if.mm10, sw_if.mm1, sw_if.ss10, sw_if.ss1,
           sw_if.cs10, sw_if.cs1, sw_if.running, sw_if.lap_active, sw_if.overflow};
    exp = expect_out(m);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got %h expected %h", $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance n active edges, checking against the model at every falling edge
  task automatic go_edges(input int n);
    repeat (n) begin
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit s, input bit l);
    sw_if.start_stop = s;
    sw_if.lap        = l;
    go_edges(1);
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
  endtask

  task automatic wait_running(input string name);
    for (int i = 0; i < 20 && !sw_if.running; i++) go_edges(1);
    lit(name, 32'(sw_if.running), 32'd1);
  endtask

  // Reset asserted mid-cycle, held for two edges, released away from the edge
  task automatic async_reset(input bit do_lit);
    @(negedge clk);
    cycle_check();
    #2 rst = 1'b0;
    #1;
    if (do_lit) begin
      lit("rst_time", 32'(sw_if.time_bcd), 32'h0);
      lit("rst_seg_mm10", 32'(sw_if.mm10), 32'h40);
      lit("rst_seg_cs1", 32'(sw_if.cs1), 32'h40);
      lit("rst_running", 32'(sw_if.running), 32'd0);
      lit("rst_overflow", 32'(sw_if.overflow), 32'd0);
    end
    @(posedge clk);
    #2;
    go_edges(2);
    rst = 1'b1;
  endtask

  initial begin
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    go_edges(3);
    rst = 1'b1;

    // Reset values
    lit("init_time", 32'(sw_if.time_bcd), 32'h0);
    lit("init_seg_ss10", 32'(sw_if.ss10), 32'h40);
    lit("init_running", 32'(sw_if.running), 32'd0);
    lit("init_lap_active", 32'(sw_if.lap_active), 32'd0);
    go_edges(6);
    lit("no_spurious_edge", 32'(sw_if.running), 32'd0);

    // Start and count: 100 ticks of TD cycles -> 00:01.00
    press(1, 0);
    wait_running("run_a_timeout");
    go_edges(200);
    lit("count_1s", 32'(sw_if.time_bcd), 32'h000100);

    // Pause, then clear from PAUSE, then lap ignored in IDLE
    press(1, 0);
    go_edges(5);
    lit("paused", 32'(sw_if.running), 32'd0);
    press(0, 1);
    go_edges(5);
    lit("clear_time", 32'(sw_if.time_bcd), 32'h0);
    lit("clear_lap_active", 32'(sw_if.lap_active), 32'd0);
    press(0, 1);
    go_edges(5);
    lit("idle_lap_time", 32'(sw_if.time_bcd), 32'h0);
    lit("idle_lap_running", 32'(sw_if.running), 32'd0);

    // Pause mid-tick and resume: partial tick preserved
    press(1, 0);
    wait_running("run_b_timeout");
    lit("resume_start", 32'(sw_if.time_bcd), 32'h0);
    go_edges(1);
    press(1, 0);
    go_edges(103);
    lit("pause_hold", 32'(sw_if.time_bcd), 32'h000002);
    lit("pause_running", 32'(sw_if.running), 32'd0);
    press(1, 0);
    wait_running("run_c_timeout");
    lit("resume_before_tick", 32'(sw_if.time_bcd), 32'h000002);
    go_edges(1);
    lit("resume_tick", 32'(sw_if.time_bcd), 32'h000003);

    // Lap freeze at 00:00.50 while the live count continues
    go_edges(91);
    press(0, 1);
    go_edges(3);
    lit("lap_on_time", 32'(sw_if.time_bcd), 32'h000050);
    lit("lap_on_flag", 32'(sw_if.lap_active), 32'd1);
    go_edges(75);
    lit("lap_frozen", 32'(sw_if.time_bcd), 32'h000050);
    press(0, 1);
    go_edges(3);
    lit("lap_off_time", 32'(sw_if.time_bcd), 32'h000090);
    lit("lap_off_flag", 32'(sw_if.lap_active), 32'd0);

    // Simultaneous start and lap: start wins, lap state untouched
    press(1, 1);
    go_edges(5);
    lit("coll_running", 32'(sw_if.running), 32'd0);
    lit("coll_lap0", 32'(sw_if.lap_active), 32'd0);
    press(1, 0);
    go_edges(5);
    press(0, 1);
    go_edges(5);
    lit("lap_again", 32'(sw_if.lap_active), 32'd1);
    press(1, 1);
    go_edges(5);
    lit("coll2_running", 32'(sw_if.running), 32'd0);
    lit("coll2_lap1", 32'(sw_if.lap_active), 32'd1);
    press(0, 1);
    go_edges(5);
    lit("clear2_lap", 32'(sw_if.lap_active), 32'd0);
    lit("clear2_time", 32'(sw_if.time_bcd), 32'h0);

    // Wrap at 01:59.99
    press(1, 0);
    wait_running("run_d_timeout");
    go_edges(23998);
    lit("max_time", 32'(sw_if.time_bcd), 32'h015999);
    lit("max_no_ovf", 32'(sw_if.overflow), 32'd0);
    go_edges(2);
    lit("wrap_time", 32'(sw_if.time_bcd), 32'h0);
    lit("wrap_ovf", 32'(sw_if.overflow), 32'd1);
    go_edges(1);
    lit("ovf_one_cycle", 32'(sw_if.overflow), 32'd0);

    // Reset while running, then release with buttons low
    async_reset(1'b1);
    go_edges(10);
    lit("post_rst_running", 32'(sw_if.running), 32'd0);
    lit("post_rst_time", 32'(sw_if.time_bcd), 32'h0);

    // Start held through reset release gives exactly one edge
    sw_if.start_stop = 1'b1;
    async_reset(1'b0);
    go_edges(8);
    lit("held_start_run", 32'(sw_if.running), 32'd1);
    go_edges(10);
    lit("held_start_once", 32'(sw_if.running), 32'd1);
    sw_if.start_stop = 1'b0;
    go_edges(4);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int r;
      int h;
      r = int'($urandom_range(0, 99));
      h = int'($urandom_range(1, 4));
      if (r < 3) begin
        async_reset(1'b0);
      end else begin
        sw_if.start_stop = (r < 50) || (r >= 90);
        sw_if.lap        = (r >= 50);
        go_edges(h);
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
      end
      go_edges(int'($urandom_range(1, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_ctrl.md
# stopwatch_lap_ctrl

Parametrised stopwatch core with a start/stop/resume control FSM, a lap (split) display freeze, and a properly cascaded BCD time base (centiseconds, seconds, minutes) driving six seven-segment digits. Sits between the board push-buttons and the seven-segment display bank. The prescaler and the whole count chain are gated from one clock, with no derived clocks. Clock-frequency independent via `TICK_DIV`.

## Interface
- `TICK_DIV`, 500000, clock cycles per centisecond tick (50 MHz → 100 Hz); ≥2
- `MAX_MIN`, 59, highest minute value before wrap; range 1..99
- `SYNC_STAGES`, 2, synchronizer flops per button input; ≥2

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `start_stop`  in  1  button, active-high level, asynchronous to `clk`
- `lap`  in  1  button, active-high level, asynchronous to `clk`
- `time_bcd`  out  24  displayed time {mm10,mm1,ss10,ss1,cs10,cs1}, 4-bit BCD each
- `mm10`,`mm1`,`ss10`,`ss1`,`cs10`,`cs1`  out  7 each  segments {g,f,e,d,c,b,a}, active-low, decoded from `time_bcd`
- `running`  out  1  high in RUN
- `lap_active`  out  1  display frozen by lap
- `overflow`  out  1  one-cycle pulse on wrap to 00:00.00

## Operation
- Each button passes through a `SYNC_STAGES` synchronizer, then a rising-edge detector. Sync and edge flops reset to 0. A button held through reset release yields one edge.
- FSM states are IDLE, RUN, and PAUSE. Reset enters IDLE.
  - IDLE: start edge → RUN. Lap edge is ignored.
  - RUN: start edge → PAUSE. Lap edge toggles `lap_active`.
    - 0→1 copies the live count into the display register.
    - 1→0 returns the display to the live count.
  - PAUSE: start edge → RUN, resuming without a clear. Lap edge clears all counts, the prescaler and `lap_active`, then goes to IDLE.
- If start and lap edges occur in the same cycle, start wins and lap is dropped.
- Prescaler counts 0..`TICK_DIV`-1 only in RUN. At `TICK_DIV`-1 it returns to 0 and issues a tick. In PAUSE it holds, so a partial tick is preserved.
- Each tick increments the BCD chain:
  - cs runs 00..99, then carries into ss.
  - ss runs 00..59, then carries into mm.
  - mm runs 00..`MAX_MIN` (BCD), then wraps.
- At `MAX_MIN`:59.99, a tick produces 00:00.00 and pulses `overflow` in that same cycle. Counting continues.
- `time_bcd` shows the live count when `lap_active`=0 and the latched lap value when `lap_active`=1. The live count keeps running while frozen.
- Segment decode is combinational from `time_bcd`, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Non-BCD codes are unreachable; decode them to 7'h7F.

## Timing
- Reset values:
  - state IDLE; prescaler, counts and lap register all 0
  - `time_bcd`=0, every segment output 7'h40
  - `running`=0, `lap_active`=0, `overflow`=0
- Reset is asynchronous: any state, mid-tick or frozen, returns to the reset values immediately.
- Button latency:
  - Input first sampled high at edge k.
  - Edge pulse is high during cycle k+`SYNC_STAGES`.
  - State, `running`, `lap_active` and the lap latch update at edge k+`SYNC_STAGES`+1.
- First tick after entering RUN from IDLE comes exactly `TICK_DIV` cycles after `running` rises. The count register updates on the edge following the tick cycle.
- A lap latch in the same cycle as a tick captures the pre-increment value.
- A start edge in the same cycle as a tick: the tick is applied, then the FSM enters PAUSE.
- `overflow` is registered and high for exactly one cycle.
- Button bounce is out of scope. Every synchronized edge acts.

## Test plan
- Reset sequence: hold `rst`=0 mid-run, then release → `time_bcd`=0x000000, all segments 7'h40, `running`=0, no spurious edge with buttons low.
- Start and count (`TICK_DIV`=4): pulse start, run 400 cycles after `running` rises → `time_bcd`=0x000100 (00:01.00); cs carries 99→00 into ss exactly once.
- Pause and resume: start, wait 10 cycles (2 ticks + 2 cycles), press start → hold at 0x000002 for 100 cycles. Press start again → next tick after 2 more cycles gives 0x000003.
- Lap freeze: during RUN press lap at 0x000050 → display holds 0x000050 with `lap_active`=1 while 40 further ticks elapse. Second lap → `time_bcd`=0x000090, `lap_active`=0.
- Clear from PAUSE: pause at any value, press lap → IDLE, `time_bcd`=0, `lap_active`=0. Lap in IDLE → no change.
- Wrap and collisions (`TICK_DIV`=2, `MAX_MIN`=1):
  - Run to 01:59.99; next tick → 0x000000 with `overflow` high for one cycle.
  - Start and lap edges in the same cycle in RUN → PAUSE, `lap_active` unchanged.
